imem_dmem_arbiter: RTL and testbench

//  Shares one single-port backing memory between the pipeline's instruction-fetch port (IF)
//  and its load/store port (MEM stage: ld/sd). Sits between processor and memory model.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/imem_dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter, its memory model and the pipeline.
package mem_arb_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int DW_ALIGN_BITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch was waiting; raises force_i at the limit.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic req,
    output logic force_i
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_i = req && (cnt == LIM);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port backing memory between the fetch port and the load/store port.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [31:0]     if_rdata,
    output logic            if_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_valid,
    output logic [1:0]      arb_state
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              in_idle;
    logic              grant_i;
    logic              grant_d;
    logic              force_i;
    logic              word_sel;
    logic [31:0]       if_word;
    logic [31:0]       if_rdata_q;
    logic [XLEN-1:0]   d_rdata_q;
    logic [4:0]        unused_addr_bits;

    assign unused_addr_bits = {if_addr[1:0], d_addr[DW_ALIGN_BITS-1:0]};

    // The unreachable encoding 3 behaves exactly like IDLE.
    assign in_idle = !(state_q == ST_WAIT_I || state_q == ST_WAIT_D);

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (grant_d && if_req),
        .clr     (grant_i || (in_idle && !if_req)),
        .req     (if_req),
        .force_i (force_i)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            ST_WAIT_I: if (mem_valid) state_d = ST_IDLE;
            ST_WAIT_D: if (mem_valid) state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                if (force_i) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_i = 1'b1;
                end
                if (grant_i) begin
                    state_d = ST_WAIT_I;
                end else if (grant_d) begin
                    state_d = ST_WAIT_D;
                end
            end
        endcase
    end

    // Request latches stay stable for the whole memory transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            word_sel  <= 1'b0;
        end else begin
            mem_req <= grant_i || grant_d;
            if (grant_i) begin
                mem_addr <= {if_addr[XLEN-1:DW_ALIGN_BITS], {DW_ALIGN_BITS{1'b0}}};
                mem_we   <= 1'b0;
                word_sel <= if_addr[2];
            end else if (grant_d) begin
                mem_addr  <= {d_addr[XLEN-1:DW_ALIGN_BITS], {DW_ALIGN_BITS{1'b0}}};
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_ready) if_rdata_q <= if_word;
            if (d_ready)  d_rdata_q  <= mem_rdata;
        end
    end

    // Responses pass straight through on mem_valid and are held afterwards.
    always_comb begin
        if_ready  = (state_q == ST_WAIT_I) && mem_valid;
        d_ready   = (state_q == ST_WAIT_D) && mem_valid;
        if_word   = word_sel ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
        if_rdata  = if_ready ? if_word : if_rdata_q;
        d_rdata   = d_ready ? mem_rdata : d_rdata_q;
        arb_state = state_q;
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter with a fixed 2-cycle memory model.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_valid;
    logic [1:0]  arb_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem_array [0:15];
    logic        pending;
    logic        model_valid;
    logic        spurious_valid;
    logic [63:0] model_rdata;

    imem_dmem_arbiter #(
        .XLEN         (64),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .arb_state (arb_state)
    );

    always #5 clk = ~clk;

    assign mem_valid = model_valid | spurious_valid;
    assign mem_rdata = model_rdata;

    // Memory answers two cycles after the request cycle; it shares the arbiter's reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= 1'b0;
            model_valid <= 1'b0;
            model_rdata <= '0;
        end else begin
            model_valid <= 1'b0;
            if (mem_req) begin
                pending <= 1'b1;
            end else if (pending) begin
                pending     <= 1'b0;
                model_valid <= 1'b1;
                model_rdata <= mem_array[mem_addr[6:3]];
                if (mem_we) mem_array[mem_addr[6:3]] <= mem_wdata;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic i_req, input logic [63:0] i_addr, input logic dq,
                                 input logic dwe, input logic [63:0] da, input logic [63:0] dw);
        if_req  = i_req;
        if_addr = i_addr;
        d_req   = dq;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dw;
    endtask

    task automatic waitReady(input logic for_data, input int budget, output int cycles, output logic seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (for_data ? d_ready : if_ready) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        logic        seen;
        int          d_cnt;
        int          i_grants;
        int          n_grants;
        logic [11:0] grant_seq;
        int          late_ready;

        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        spurious_valid = 1'b0;
        for (int i = 0; i < 16; i++) mem_array[i] = 64'h0;
        mem_array[0] = 64'hAAAA_BBBB_0000_0013;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_state", 64'(arb_state), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_if_rdata", 64'(if_rdata), 64'd0);
        checkOutput("rst_mem_addr", mem_addr, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] step 1: fetch only");
        applyStimulus(1, 64'h4, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t1_state", 64'(arb_state), 64'd1);
        checkOutput("t1_mem_req", 64'(mem_req), 64'd1);
        checkOutput("t1_mem_addr", mem_addr, 64'h0);
        checkOutput("t1_mem_we", 64'(mem_we), 64'd0);
        waitReady(0, 10, cyc, seen);
        checkOutput("t1_ready_seen", 64'(seen), 64'd1);
        checkOutput("t1_latency", 64'(cyc), 64'd2);
        checkOutput("t1_if_rdata", 64'(if_rdata), 64'hAAAABBBB);
        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t1_ready_pulse", 64'(if_ready), 64'd0);
        checkOutput("t1_rdata_hold", 64'(if_rdata), 64'hAAAABBBB);
        checkOutput("t1_back_idle", 64'(arb_state), 64'd0);

        $display("[TB] step 2: store then load");
        applyStimulus(0, 64'h0, 1, 1, 64'h10, 64'h1234);
        @(posedge clk);
        #1;
        checkOutput("t2_sd_state", 64'(arb_state), 64'd2);
        checkOutput("t2_sd_we", 64'(mem_we), 64'd1);
        checkOutput("t2_sd_addr", mem_addr, 64'h10);
        checkOutput("t2_sd_wdata", mem_wdata, 64'h1234);
        waitReady(1, 10, cyc, seen);
        checkOutput("t2_sd_ready", 64'(seen), 64'd1);
        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        applyStimulus(0, 64'h0, 1, 0, 64'h10, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t2_ld_we", 64'(mem_we), 64'd0);
        waitReady(1, 10, cyc, seen);
        checkOutput("t2_ld_ready", 64'(seen), 64'd1);
        checkOutput("t2_ld_rdata", d_rdata, 64'h1234);
        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;

        $display("[TB] step 3: simultaneous requests");
        applyStimulus(1, 64'h0, 1, 0, 64'h10, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t3_first_d", 64'(arb_state), 64'd2);
        waitReady(1, 10, cyc, seen);
        checkOutput("t3_d_ready", 64'(seen), 64'd1);
        applyStimulus(1, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t3_idle_between", 64'(arb_state), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t3_then_i", 64'(arb_state), 64'd1);
        waitReady(0, 10, cyc, seen);
        checkOutput("t3_i_ready", 64'(seen), 64'd1);
        checkOutput("t3_if_rdata", 64'(if_rdata), 64'h00000013);
        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;

        $display("[TB] step 4: starvation limit");
        applyStimulus(1, 64'h4, 1, 0, 64'h10, 64'h0);
        d_cnt     = 0;
        i_grants  = 0;
        n_grants  = 0;
        grant_seq = '0;
        for (int c = 0; c < 200 && d_cnt < 6; c++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (n_grants < 6) grant_seq = {grant_seq[9:0], arb_state};
                if (arb_state == 2'd1) i_grants++;
                n_grants++;
            end
            if (if_ready) if_req = 1'b0;
            if (d_ready) d_cnt++;
        end
        d_req = 1'b0;
        checkOutput("t4_d_count", 64'(d_cnt), 64'd6);
        checkOutput("t4_grant_seq", 64'(grant_seq), 64'hAA6);
        checkOutput("t4_i_grants", 64'(i_grants), 64'd1);
        checkOutput("t4_d_rdata", d_rdata, 64'h1234);
        @(posedge clk);
        #1;

        $display("[TB] step 5: reset during data transaction");
        applyStimulus(0, 64'h0, 1, 1, 64'h20, 64'h55);
        @(posedge clk);
        #1;
        checkOutput("t5_in_wait_d", 64'(arb_state), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_state", 64'(arb_state), 64'd0);
        checkOutput("t5_mem_req", 64'(mem_req), 64'd0);
        checkOutput("t5_mem_we", 64'(mem_we), 64'd0);
        checkOutput("t5_mem_addr", mem_addr, 64'd0);
        checkOutput("t5_mem_wdata", mem_wdata, 64'd0);
        checkOutput("t5_if_rdata", 64'(if_rdata), 64'd0);
        checkOutput("t5_d_rdata", d_rdata, 64'd0);
        checkOutput("t5_d_ready", 64'(d_ready), 64'd0);
        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        late_ready = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (d_ready || if_ready) late_ready++;
        end
        checkOutput("t5_no_late_ready", 64'(late_ready), 64'd0);
        checkOutput("t5_stays_idle", 64'(arb_state), 64'd0);

        $display("[TB] step 6: spurious mem_valid in IDLE");
        spurious_valid = 1'b1;
        #1;
        checkOutput("t6_no_d_ready", 64'(d_ready), 64'd0);
        checkOutput("t6_no_if_ready", 64'(if_ready), 64'd0);
        @(posedge clk);
        #1;
        spurious_valid = 1'b0;
        checkOutput("t6_state", 64'(arb_state), 64'd0);
        checkOutput("t6_d_rdata", d_rdata, 64'd0);
        applyStimulus(0, 64'h0, 1, 0, 64'h17, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t6_state_d", 64'(arb_state), 64'd2);
        checkOutput("t6_aligned", mem_addr, 64'h10);
        waitReady(1, 10, cyc, seen);
        checkOutput("t6_ready", 64'(seen), 64'd1);
        checkOutput("t6_rdata", d_rdata, 64'h1234);
        applyStimulus(0, 64'h0, 0, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
